// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid pipeline register with flush and bubble-zeroed control
// Optional PIPE_STAGE_PERF_EN adds saturating stall/flush counters; otherwise both counter ports read zero.
module pipe_stage_reg #(
    parameter int DATA_W        = 64,
    parameter int CTRL_W        = 16,
    parameter int FLUSH_KEEP_IN = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DATA_W-1:0]  main_data;
    logic [CTRL_W-1:0]  main_ctrl;
    logic [DATA_W-1:0]  skid_data;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic               ld_main_in;
    logic               ld_main_skid;
    logic               ld_skid;
    logic               in_fire;
    logic               out_fire;

    // Both handshake flags come from registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
            if ((FLUSH_KEEP_IN != 0) && in_fire) begin
                state_d    = ONE;
                ld_main_in = 1'b1;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d    = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d = TWO;
                        ld_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d      = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // main_data is left untouched on drain so out_data holds its last value during bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (ld_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (ld_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (ld_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush && (state_q != EMPTY) && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and scoreboarded bench for pipe_stage_reg
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    logic        d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready, d0_flush;
    logic [63:0] d0_in_data, d0_out_data;
    logic [15:0] d0_in_ctrl, d0_out_ctrl, d0_flush_cnt;
    logic [31:0] d0_stall_cnt;

    logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_flush;
    logic [15:0] d1_in_data, d1_out_data, d1_flush_cnt;
    logic [3:0]  d1_in_ctrl, d1_out_ctrl;
    logic [31:0] d1_stall_cnt;

    logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_flush;
    logic [7:0]  d2_in_data, d2_out_data;
    logic        d2_in_ctrl, d2_out_ctrl;
    logic [15:0] d2_flush_cnt;
    logic [31:0] d2_stall_cnt;

    pipe_stage_reg dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(d0_in_valid), .in_ready(d0_in_ready), .in_data(d0_in_data), .in_ctrl(d0_in_ctrl),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_data(d0_out_data), .out_ctrl(d0_out_ctrl),
        .flush(d0_flush), .stall_cnt(d0_stall_cnt), .flush_cnt(d0_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .FLUSH_KEEP_IN(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data), .in_ctrl(d1_in_ctrl),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data), .out_ctrl(d1_out_ctrl),
        .flush(d1_flush), .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(1)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data), .in_ctrl(d2_in_ctrl),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data), .out_ctrl(d2_out_ctrl),
        .flush(d2_flush), .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset_n = 1'b0;
        d0_in_valid = 1'b1; d0_in_data = 64'h1234; d0_in_ctrl = 16'h00A5; d0_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (d0_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h want 0", d0_out_valid); end
        n_tests++; if (d0_out_ctrl !== 16'h0) begin n_fail++; $display("FAIL reset_out_ctrl: got %0h want 0", d0_out_ctrl); end
        n_tests++; if (d0_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 1", d0_in_ready); end
        n_tests++; if (d0_out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", d0_out_data); end
        reset_n = 1'b1;
        @(negedge clk);
        d0_in_valid = 1'b0;
        n_tests++; if (d0_out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_first_valid: got %0h want 1", d0_out_valid); end
        n_tests++; if (d0_out_data !== 64'h1234) begin n_fail++; $display("FAIL reset_first_data: got %0h want 1234", d0_out_data); end
        n_tests++; if (d0_out_ctrl !== 16'h00A5) begin n_fail++; $display("FAIL reset_first_ctrl: got %0h want a5", d0_out_ctrl); end
        d0_out_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (d0_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %0h want 0", d0_out_valid); end
        n_tests++; if (d0_out_ctrl !== 16'h0) begin n_fail++; $display("FAIL bubble_ctrl: got %0h want 0", d0_out_ctrl); end
        n_tests++; if (d0_out_data !== 64'h1234) begin n_fail++; $display("FAIL bubble_data_hold: got %0h want 1234", d0_out_data); end
    endtask

    task automatic test_back_pressure;
        d0_out_ready = 1'b0;
        d0_in_valid = 1'b1; d0_in_data = 64'h11; d0_in_ctrl = 16'h0001;
        @(negedge clk);
        n_tests++; if (d0_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %0h want 1", d0_in_ready); end
        d0_in_data = 64'h22; d0_in_ctrl = 16'h0002;
        @(negedge clk);
        n_tests++; if (d0_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_two: got %0h want 0", d0_in_ready); end
        d0_in_data = 64'h33; d0_in_ctrl = 16'h0003;
        @(negedge clk);
        n_tests++; if (d0_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_c_blocked: got %0h want 0", d0_in_ready); end
        n_tests++; if (d0_out_data !== 64'h11) begin n_fail++; $display("FAIL bp_hold_a: got %0h want 11", d0_out_data); end
        n_tests++; if (d0_out_ctrl !== 16'h0001) begin n_fail++; $display("FAIL bp_hold_a_ctrl: got %0h want 1", d0_out_ctrl); end
        d0_in_valid = 1'b0; d0_out_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (d0_out_data !== 64'h22 || d0_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_b: got v=%0h d=%0h want v=1 d=22", d0_out_valid, d0_out_data); end
        n_tests++; if (d0_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %0h want 1", d0_in_ready); end
        d0_in_valid = 1'b1;
        @(negedge clk);
        d0_in_valid = 1'b0;
        n_tests++; if (d0_out_data !== 64'h33 || d0_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_c: got v=%0h d=%0h want v=1 d=33", d0_out_valid, d0_out_data); end
        @(negedge clk);
        n_tests++; if (d0_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0h want 0", d0_out_valid); end
    endtask

    task automatic test_streaming;
        d0_out_ready = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) begin
                n_tests++; if (d0_out_valid !== 1'b1 || d0_out_data !== 64'h1000 + 64'(k - 1)) begin
                    n_fail++; $display("FAIL stream_out[%0d]: got v=%0h d=%0h want v=1 d=%0h", k - 1, d0_out_valid, d0_out_data, 64'h1000 + 64'(k - 1));
                end
            end
            n_tests++; if (d0_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %0h want 1", k, d0_in_ready); end
            d0_in_valid = (k < 100);
            d0_in_data  = 64'h1000 + 64'(k);
            @(negedge clk);
        end
        n_tests++; if (d0_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_tail: got %0h want 0", d0_out_valid); end
    endtask

    task automatic test_flush;
        d0_out_ready = 1'b0;
        d0_in_valid = 1'b1; d0_in_data = 64'hA1; d0_in_ctrl = 16'h0001;
        @(negedge clk);
        d0_in_data = 64'hA2; d0_in_ctrl = 16'h0002;
        @(negedge clk);
        n_tests++; if (d0_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_setup_two: got %0h want 0", d0_in_ready); end
        d0_flush = 1'b1; d0_in_data = 64'hA3; d0_in_ctrl = 16'h0003;
        @(negedge clk);
        d0_flush = 1'b0; d0_in_valid = 1'b0;
        n_tests++; if (d0_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", d0_out_valid); end
        n_tests++; if (d0_out_ctrl !== 16'h0) begin n_fail++; $display("FAIL flush_ctrl: got %0h want 0", d0_out_ctrl); end
        n_tests++; if (d0_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0h want 1", d0_in_ready); end
        n_tests++; if (d0_flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", d0_flush_cnt, PERF ? 1 : 0); end
        d0_out_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (d0_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_residue: got %0h want 0", d0_out_valid); end
        d0_flush = 1'b1;
        @(negedge clk);
        d0_flush = 1'b0;
        n_tests++; if (d0_flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL flush_cnt_empty: got %0d want %0d", d0_flush_cnt, PERF ? 1 : 0); end
    endtask

    task automatic test_flush_keep_in;
        d1_out_ready = 1'b0;
        d1_in_valid = 1'b1; d1_in_data = 16'hB1; d1_in_ctrl = 4'h5;
        @(negedge clk);
        d1_flush = 1'b1; d1_in_data = 16'hB2; d1_in_ctrl = 4'h3;
        @(negedge clk);
        d1_flush = 1'b0; d1_in_valid = 1'b0;
        n_tests++; if (d1_out_valid !== 1'b1 || d1_out_data !== 16'hB2) begin n_fail++; $display("FAIL keep_in_data: got v=%0h d=%0h want v=1 d=b2", d1_out_valid, d1_out_data); end
        n_tests++; if (d1_out_ctrl !== 4'h3) begin n_fail++; $display("FAIL keep_in_ctrl: got %0h want 3", d1_out_ctrl); end
        n_tests++; if (d1_flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL keep_in_flush_cnt: got %0d want %0d", d1_flush_cnt, PERF ? 1 : 0); end
        n_tests++; if (d1_stall_cnt !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL keep_in_stall_cnt: got %0d want %0d", d1_stall_cnt, PERF ? 1 : 0); end
        d1_out_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (d1_out_valid !== 1'b0) begin n_fail++; $display("FAIL keep_in_single: got %0h want 0", d1_out_valid); end
    endtask

    task automatic test_counters;
        logic [31:0] s0;
        d0_out_ready = 1'b0;
        d0_in_valid = 1'b1; d0_in_data = 64'h77;
        @(negedge clk);
        d0_in_valid = 1'b0;
        s0 = d0_stall_cnt;
        repeat (7) @(negedge clk);
        n_tests++; if (d0_stall_cnt - s0 !== (PERF ? 32'd7 : 32'd0)) begin n_fail++; $display("FAIL stall_cnt_7: got %0d want %0d", d0_stall_cnt - s0, PERF ? 7 : 0); end
`ifdef PIPE_STAGE_PERF_EN
        dut0.stall_q = 32'hFFFF_FFFD;
        dut0.flush_q = 16'hFFFE;
`endif
        repeat (5) @(negedge clk);
        n_tests++; if (d0_stall_cnt !== (PERF ? 32'hFFFF_FFFF : 32'd0)) begin n_fail++; $display("FAIL stall_cnt_sat: got %0h want %0h", d0_stall_cnt, PERF ? 32'hFFFF_FFFF : 32'd0); end
        d0_flush = 1'b1;
        @(negedge clk);
        d0_flush = 1'b0; d0_in_valid = 1'b1; d0_in_data = 64'h78;
        n_tests++; if (d0_flush_cnt !== (PERF ? 16'hFFFF : 16'd0)) begin n_fail++; $display("FAIL flush_cnt_max: got %0h want %0h", d0_flush_cnt, PERF ? 16'hFFFF : 16'd0); end
        @(negedge clk);
        d0_in_valid = 1'b0; d0_flush = 1'b1;
        @(negedge clk);
        d0_flush = 1'b0;
        n_tests++; if (d0_flush_cnt !== (PERF ? 16'hFFFF : 16'd0)) begin n_fail++; $display("FAIL flush_cnt_sat: got %0h want %0h", d0_flush_cnt, PERF ? 16'hFFFF : 16'd0); end
        d0_out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        d0_out_ready = 1'b0;
        d0_in_valid = 1'b1; d0_in_data = 64'hC1; d0_in_ctrl = 16'h00C1;
        @(negedge clk);
        d0_in_data = 64'hC2;
        @(negedge clk);
        d0_in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (d0_out_valid !== 1'b0 || d0_out_ctrl !== 16'h0) begin n_fail++; $display("FAIL mid_reset_async: got v=%0h c=%0h want 0 0", d0_out_valid, d0_out_ctrl); end
        n_tests++; if (d0_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %0h want 1", d0_in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        n_tests++; if (d0_stall_cnt !== 32'd0 || d0_flush_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d %0d want 0 0", d0_stall_cnt, d0_flush_cnt); end
        d0_in_valid = 1'b1; d0_in_data = 64'hD1; d0_out_ready = 1'b1;
        @(negedge clk);
        d0_in_valid = 1'b0;
        n_tests++; if (d0_out_valid !== 1'b1 || d0_out_data !== 64'hD1) begin n_fail++; $display("FAIL mid_reset_first: got v=%0h d=%0h want v=1 d=d1", d0_out_valid, d0_out_data); end
        @(negedge clk);
        n_tests++; if (d0_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_discard: got %0h want 0", d0_out_valid); end
    endtask

    task automatic test_random;
        logic [7:0] sb[$];
        logic [7:0] seq;
        logic [7:0] exp_d;
        int         stalls;
        seq = 8'd0;
        stalls = 0;
        d2_in_ctrl = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!d2_out_valid) begin
                n_tests++; if (d2_out_ctrl !== 1'b0) begin n_fail++; $display("FAIL rand_bubble_ctrl[%0d]: got %0h want 0", c, d2_out_ctrl); end
            end
            d2_in_valid  = (c < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
            d2_out_ready = (c < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
            d2_in_data   = seq;
            if (d2_out_valid && !d2_out_ready) stalls++;
            if (d2_out_valid && d2_out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra_beat[%0d]: got %0h want none", c, d2_out_data);
                end else begin
                    exp_d = sb.pop_front();
                    if (d2_out_data !== exp_d || d2_out_ctrl !== 1'b1) begin
                        n_fail++; $display("FAIL rand_order[%0d]: got d=%0h c=%0h want d=%0h c=1", c, d2_out_data, d2_out_ctrl, exp_d);
                    end
                end
            end
            if (d2_in_valid && d2_in_ready) begin
                sb.push_back(seq);
                seq = seq + 8'd1;
            end
        end
        n_tests++; if (sb.size() != 0 || d2_out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_loss: got %0d pending v=%0h want 0", sb.size(), d2_out_valid); end
        n_tests++; if (seq < 8'd50) begin n_fail++; $display("FAIL rand_progress: got %0d beats want >=50", seq); end
        n_tests++; if (d2_stall_cnt !== (PERF ? 32'(stalls) : 32'd0)) begin n_fail++; $display("FAIL rand_stall_cnt: got %0d want %0d", d2_stall_cnt, PERF ? stalls : 0); end
        n_tests++; if (d2_flush_cnt !== 16'd0) begin n_fail++; $display("FAIL rand_flush_cnt: got %0d want 0", d2_flush_cnt); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        d0_in_valid = 1'b0; d0_in_data = '0; d0_in_ctrl = '0; d0_out_ready = 1'b0; d0_flush = 1'b0;
        d1_in_valid = 1'b0; d1_in_data = '0; d1_in_ctrl = '0; d1_out_ready = 1'b0; d1_flush = 1'b0;
        d2_in_valid = 1'b0; d2_in_data = '0; d2_in_ctrl = 1'b0; d2_out_ready = 1'b0; d2_flush = 1'b0;
        test_reset();
        test_back_pressure();
        test_streaming();
        test_flush();
        test_flush_keep_in();
        test_counters();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
